// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus master. It turns single-word host requests into
// /AS, /UDS, /LDS and R/W cycles, and terminates each cycle on /DTACK, /BERR or a timeout.
module m68k_bus_initiator #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ,
   input  logic        REQ_RW,
   input  logic [22:0] REQ_ADDR,
   input  logic        REQ_UDS_EN,
   input  logic        REQ_LDS_EN,
   input  logic [15:0] REQ_WDATA,
   output logic        BUSY,
   output logic        ACK,
   output logic        ERR,
   output logic [15:0] RDATA,
   output logic [22:0] ADDRESS,
   output logic        AS,
   output logic        UDS,
   output logic        LDS,
   output logic        RW,
   output logic [15:0] DATA_OUT,
   output logic        DATA_OE,
   input  logic [15:0] DATA_IN,
   input  logic        DTACK,
   input  logic        BERR
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_STROBE,
      S_WAIT,
      S_RECOVER
   } state_t;

   state_t      state_reg;
   logic [15:0] cnt_reg;
   logic        uds_en_reg;
   logic        lds_en_reg;
   logic        recover_first_reg;
   logic        dtack_meta_reg;
   logic        dtack_s_reg;
   logic        berr_meta_reg;
   logic        berr_s_reg;

   logic        req_word;
   logic        timed_out;

   // A request with no byte enabled is a full word access.
   assign req_word  = !REQ_UDS_EN && !REQ_LDS_EN;
   assign timed_out = (cnt_reg == CNT_LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg         <= S_IDLE;
         cnt_reg           <= '0;
         uds_en_reg        <= 1'b0;
         lds_en_reg        <= 1'b0;
         recover_first_reg <= 1'b0;
         dtack_meta_reg    <= 1'b1;
         dtack_s_reg       <= 1'b1;
         berr_meta_reg     <= 1'b1;
         berr_s_reg        <= 1'b1;
         BUSY              <= 1'b0;
         ACK               <= 1'b0;
         ERR               <= 1'b0;
         RDATA             <= '0;
         ADDRESS           <= '0;
         AS                <= 1'b1;
         UDS               <= 1'b1;
         LDS               <= 1'b1;
         RW                <= 1'b1;
         DATA_OUT          <= '0;
         DATA_OE           <= 1'b0;
      end else begin
         dtack_meta_reg <= DTACK;
         dtack_s_reg    <= dtack_meta_reg;
         berr_meta_reg  <= BERR;
         berr_s_reg     <= berr_meta_reg;
         ACK            <= 1'b0;
         ERR            <= 1'b0;

         case (state_reg)
            S_IDLE: begin
               if (REQ) begin
                  ADDRESS    <= REQ_ADDR;
                  RW         <= REQ_RW;
                  DATA_OUT   <= REQ_WDATA;
                  uds_en_reg <= REQ_UDS_EN || req_word;
                  lds_en_reg <= REQ_LDS_EN || req_word;
                  BUSY       <= 1'b1;
                  state_reg  <= S_ADDR;
               end
            end

            S_ADDR: begin
               AS <= 1'b0;
               if (RW) begin
                  UDS <= !uds_en_reg;
                  LDS <= !lds_en_reg;
               end else begin
                  DATA_OE <= 1'b1;
               end
               state_reg <= S_STROBE;
            end

            // Write strobes trail AS by one clock so data is stable first.
            S_STROBE: begin
               if (!RW) begin
                  UDS <= !uds_en_reg;
                  LDS <= !lds_en_reg;
               end
               cnt_reg   <= '0;
               state_reg <= S_WAIT;
            end

            S_WAIT: begin
               if (!berr_s_reg || !dtack_s_reg || timed_out) begin
                  AS                <= 1'b1;
                  UDS               <= 1'b1;
                  LDS               <= 1'b1;
                  ACK               <= 1'b1;
                  ERR               <= !berr_s_reg || dtack_s_reg;
                  if (berr_s_reg && !dtack_s_reg && RW)
                     RDATA <= DATA_IN;
                  cnt_reg           <= '0;
                  recover_first_reg <= 1'b1;
                  state_reg         <= S_RECOVER;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end

            // Leave once the responder has released both lines, or give up
            // on a stuck responder after the timeout.
            S_RECOVER: begin
               recover_first_reg <= 1'b0;
               if (recover_first_reg) begin
                  DATA_OE <= 1'b0;
                  RW      <= 1'b1;
               end
               if ((!recover_first_reg && dtack_s_reg && berr_s_reg) || timed_out) begin
                  BUSY      <= 1'b0;
                  DATA_OE   <= 1'b0;
                  RW        <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= S_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator: read, byte write, timeout, BERR priority,
// reset mid-cycle and back-to-back requests, all against hand-computed edge timings.
module tb_m68k_bus_initiator;

   logic        CLK;
   logic        RESET;
   logic        REQ;
   logic        REQ_RW;
   logic [22:0] REQ_ADDR;
   logic        REQ_UDS_EN;
   logic        REQ_LDS_EN;
   logic [15:0] REQ_WDATA;
   logic        BUSY;
   logic        ACK;
   logic        ERR;
   logic [15:0] RDATA;
   logic [22:0] ADDRESS;
   logic        AS;
   logic        UDS;
   logic        LDS;
   logic        RW;
   logic [15:0] DATA_OUT;
   logic        DATA_OE;
   logic [15:0] DATA_IN;
   logic        DTACK;
   logic        BERR;

   int n_checks = 0;
   int n_fail   = 0;

   m68k_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .REQ        (REQ),
      .REQ_RW     (REQ_RW),
      .REQ_ADDR   (REQ_ADDR),
      .REQ_UDS_EN (REQ_UDS_EN),
      .REQ_LDS_EN (REQ_LDS_EN),
      .REQ_WDATA  (REQ_WDATA),
      .BUSY       (BUSY),
      .ACK        (ACK),
      .ERR        (ERR),
      .RDATA      (RDATA),
      .ADDRESS    (ADDRESS),
      .AS         (AS),
      .UDS        (UDS),
      .LDS        (LDS),
      .RW         (RW),
      .DATA_OUT   (DATA_OUT),
      .DATA_OE    (DATA_OE),
      .DATA_IN    (DATA_IN),
      .DTACK      (DTACK),
      .BERR       (BERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present a request; the next tick() is the accept edge (edge 0).
   task automatic start_req(input logic rw, input logic [22:0] addr, input logic uds_en,
                            input logic lds_en, input logic [15:0] wdata);
      REQ_RW     = rw;
      REQ_ADDR   = addr;
      REQ_UDS_EN = uds_en;
      REQ_LDS_EN = lds_en;
      REQ_WDATA  = wdata;
      REQ        = 1'b1;
   endtask

   logic [22:0] addr_tab [0:4];
   int          acc_edge;
   int          n_acc;
   int          low_run;
   int          ack_seen;
   logic        busy_prev;
   logic        acked;

   initial begin
      RESET      = 1'b1;
      REQ        = 1'b0;
      REQ_RW     = 1'b1;
      REQ_ADDR   = '0;
      REQ_UDS_EN = 1'b0;
      REQ_LDS_EN = 1'b0;
      REQ_WDATA  = '0;
      DATA_IN    = '0;
      DTACK      = 1'b1;
      BERR       = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tick();

      check_val("rst_as",      AS,       1);
      check_val("rst_uds_lds", {UDS, LDS}, 2'b11);
      check_val("rst_rw",      RW,       1);
      check_val("rst_oe",      DATA_OE,  0);
      check_val("rst_busy_ack_err", {BUSY, ACK, ERR}, 3'b000);
      check_val("rst_rdata",   RDATA,    0);
      check_val("rst_address", ADDRESS,  0);
      check_val("rst_dout",    DATA_OUT, 0);

      // Word read (no byte enables => word) at 0x0BFE001 >> 1.
      start_req(1'b1, 23'h5FF000, 1'b0, 1'b0, 16'h0000);
      tick();                                   // edge 0
      REQ = 1'b0;
      check_val("rd_e0_busy", BUSY, 1);
      check_val("rd_e0_addr", ADDRESS, 23'h5FF000);
      check_val("rd_e0_as",   AS, 1);
      tick();                                   // edge 1
      check_val("rd_e1_as",   AS, 0);
      check_val("rd_e1_strb", {UDS, LDS}, 2'b00);
      check_val("rd_e1_oe",   DATA_OE, 0);
      tick();                                   // edge 2
      DTACK   = 1'b0;
      DATA_IN = 16'hA5C3;
      tick();                                   // edge 3
      tick();                                   // edge 4
      check_val("rd_e4_ack", ACK, 0);
      check_val("rd_e4_as",  AS, 0);
      tick();                                   // edge 5
      check_val("rd_e5_ack_err", {ACK, ERR}, 2'b10);
      check_val("rd_e5_rdata",   RDATA, 16'hA5C3);
      check_val("rd_e5_strobes", {AS, UDS, LDS}, 3'b111);
      DTACK   = 1'b1;
      DATA_IN = 16'hFFFF;
      tick();                                   // edge 6
      check_val("rd_e6_ack", ACK, 0);
      tick();                                   // edge 7
      check_val("rd_e7_busy", BUSY, 1);
      tick();                                   // edge 8
      check_val("rd_e8_busy", BUSY, 0);
      $display("txn read  addr=%h rdata=%h err=%0d", ADDRESS, RDATA, ERR);

      // Byte write, LDS only.
      start_req(1'b0, 23'h000123, 1'b0, 1'b1, 16'h0012);
      tick();                                   // edge 0
      REQ = 1'b0;
      check_val("wr_e0_rw",   RW, 0);
      check_val("wr_e0_dout", DATA_OUT, 16'h0012);
      check_val("wr_e0_oe",   DATA_OE, 0);
      tick();                                   // edge 1
      check_val("wr_e1_as",   AS, 0);
      check_val("wr_e1_strb", {UDS, LDS}, 2'b11);
      check_val("wr_e1_oe",   DATA_OE, 1);
      tick();                                   // edge 2
      check_val("wr_e2_strb", {UDS, LDS}, 2'b10);
      DTACK = 1'b0;
      tick();                                   // edge 3
      tick();                                   // edge 4
      check_val("wr_e4_strb_oe", {UDS, LDS, DATA_OE}, 3'b101);
      tick();                                   // edge 5
      check_val("wr_e5_ack_err", {ACK, ERR}, 2'b10);
      check_val("wr_e5_strobes", {AS, UDS, LDS}, 3'b111);
      check_val("wr_e5_oe_rw",   {DATA_OE, RW}, 2'b10);
      check_val("wr_e5_rdata",   RDATA, 16'hA5C3);
      DTACK = 1'b1;
      tick();                                   // edge 6
      check_val("wr_e6_oe_rw", {DATA_OE, RW}, 2'b01);
      tick();                                   // edge 7
      tick();                                   // edge 8
      check_val("wr_e8_busy", BUSY, 0);
      $display("txn write addr=%h wdata=%h err=%0d", ADDRESS, DATA_OUT, ERR);

      // No responder: timeout after 8 WAIT edges (edges 3..10).
      DATA_IN = 16'h1111;
      start_req(1'b1, 23'h0007FF, 1'b1, 1'b1, 16'h0000);
      for (int e = 0; e <= 9; e++) begin
         tick();
         if (e == 0) REQ = 1'b0;
      end
      check_val("to_e9_ack", ACK, 0);
      check_val("to_e9_as",  AS, 0);
      tick();                                   // edge 10
      check_val("to_e10_ack_err", {ACK, ERR}, 2'b11);
      check_val("to_e10_rdata",   RDATA, 16'hA5C3);
      check_val("to_e10_as",      AS, 1);
      tick();                                   // edge 11
      check_val("to_e11_ack_busy", {ACK, ERR, BUSY}, 3'b001);
      tick();                                   // edge 12
      check_val("to_e12_busy", BUSY, 0);
      $display("txn read  addr=%h timeout err=%0d", ADDRESS, 1);

      // BERR and DTACK together: bus error wins, RDATA untouched.
      start_req(1'b1, 23'h100000, 1'b1, 1'b0, 16'h0000);
      tick();                                   // edge 0
      REQ = 1'b0;
      tick();                                   // edge 1
      check_val("be_e1_strb", {UDS, LDS}, 2'b01);
      tick();                                   // edge 2
      DTACK   = 1'b0;
      BERR    = 1'b0;
      DATA_IN = 16'h5A5A;
      tick();
      tick();
      tick();                                   // edge 5
      check_val("be_e5_ack_err", {ACK, ERR}, 2'b11);
      check_val("be_e5_rdata",   RDATA, 16'hA5C3);
      DTACK = 1'b1;
      BERR  = 1'b1;
      tick();
      tick();
      tick();                                   // edge 8
      check_val("be_e8_busy", BUSY, 0);
      $display("txn read  addr=%h berr err=%0d", ADDRESS, 1);

      // Reset while a word write sits in WAIT.
      start_req(1'b0, 23'h000400, 1'b1, 1'b1, 16'hBEEF);
      tick();                                   // edge 0
      REQ = 1'b0;
      tick();
      tick();
      tick();                                   // edge 3, in WAIT
      check_val("rs_pre", {AS, UDS, LDS, RW, BUSY, DATA_OE}, 6'b000011);
      #3;
      RESET = 1'b1;
      #1;
      check_val("rs_async", {AS, UDS, LDS, RW, BUSY}, 5'b11110);
      check_val("rs_async_oe", DATA_OE, 0);
      #2;
      RESET = 1'b0;
      ack_seen = 0;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (ACK || BUSY) ack_seen++;
      end
      check_val("rs_no_ack", ack_seen, 0);
      $display("txn write addr=%h aborted by reset", 23'h000400);

      start_req(1'b1, 23'h000200, 1'b1, 1'b1, 16'h0000);
      tick();                                   // edge 0
      REQ = 1'b0;
      tick();
      tick();                                   // edge 2
      DTACK   = 1'b0;
      DATA_IN = 16'h3C3C;
      tick();
      tick();
      tick();                                   // edge 5
      check_val("rs_rd_ack_err", {ACK, ERR}, 2'b10);
      check_val("rs_rd_rdata",   RDATA, 16'h3C3C);
      DTACK = 1'b1;
      tick();
      tick();
      tick();                                   // edge 8
      check_val("rs_rd_busy", BUSY, 0);
      $display("txn read  addr=%h rdata=%h err=%0d", 23'h000200, RDATA, 0);

      // Back-to-back reads with REQ held high; responder pulses DTACK for one
      // clock after it sees AS low. Request fields change while BUSY.
      addr_tab[0] = 23'h010001;
      addr_tab[1] = 23'h020002;
      addr_tab[2] = 23'h030003;
      addr_tab[3] = 23'h040004;
      addr_tab[4] = 23'h7FFFFF;
      n_acc     = 0;
      acc_edge  = 0;
      low_run   = 0;
      busy_prev = 1'b0;
      acked     = 1'b0;
      start_req(1'b1, addr_tab[0], 1'b1, 1'b1, 16'h0000);
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (BUSY && !busy_prev) begin
            check_val("b2b_addr", ADDRESS, addr_tab[n_acc]);
            if (n_acc > 0) begin
               check_val("b2b_spacing", e - acc_edge, 7);
               check_val("b2b_busy_low", low_run, 1);
            end
            acc_edge = e;
            low_run  = 0;
            n_acc++;
            REQ_ADDR = addr_tab[n_acc];
            REQ_RW   = 1'b0;
            if (n_acc == 4) REQ = 1'b0;
            else REQ_RW = 1'b1;
         end else if (!BUSY) begin
            low_run++;
         end
         if (ACK) begin
            check_val("b2b_ack_addr", ADDRESS, addr_tab[n_acc-1]);
            check_val("b2b_ack_err",  ERR, 0);
            $display("txn read  addr=%h back-to-back #%0d", ADDRESS, n_acc);
         end
         if (!AS && !acked) begin
            DTACK = 1'b0;
            acked = 1'b1;
         end else begin
            DTACK = 1'b1;
            if (AS) acked = 1'b0;
         end
         busy_prev = BUSY;
      end
      check_val("b2b_accepts", n_acc, 4);
      check_val("b2b_end_busy", BUSY, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
